// File: rtl/apb_mem_slave.sv
// APB word-organised memory slave with configurable wait states, byte-lane
// strobes and slave-error response for addresses beyond the memory depth.
module apb_mem_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic                    pready,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pslverr
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int OFFS   = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int IDX_W  = ADDR_WIDTH - OFFS;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W:0] DEPTH_L  = (IDX_W + 1)'(DEPTH);
  localparam logic [3:0]     CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t state, state_next;

  logic [3:0]            cnt;
  logic                  lat_write;
  logic                  lat_err;
  logic [MEM_AW-1:0]     lat_idx;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [BYTES-1:0]      lat_strb;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  setup_idx;
  logic              setup_err;
  logic              done_write;
  logic              done_err;
  logic [MEM_AW-1:0] done_idx;
  logic              do_setup, do_dec, do_done, do_clear, do_commit;

  assign setup_idx = paddr[ADDR_WIDTH-1:OFFS];
  assign setup_err = {1'b0, setup_idx} >= DEPTH_L;

  if (OFFS > 0) begin : g_offs
    logic unused_offs;
    assign unused_offs = ^paddr[OFFS-1:0];
  end

  // With no wait states DONE is entered straight from the setup edge, so the
  // completion response must come from the live bus rather than the latches.
  assign done_write = (state == ST_IDLE) ? pwrite : lat_write;
  assign done_err   = (state == ST_IDLE) ? setup_err : lat_err;
  assign done_idx   = (state == ST_IDLE) ? setup_idx[MEM_AW-1:0] : lat_idx;

  always_comb begin
    state_next = state;
    do_setup   = 1'b0;
    do_dec     = 1'b0;
    do_done    = 1'b0;
    do_clear   = 1'b0;
    do_commit  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (psel && !penable) begin
          do_setup = 1'b1;
          if (WAIT_STATES == 0) begin
            state_next = ST_DONE;
            do_done    = 1'b1;
          end else begin
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!psel) begin
          state_next = ST_IDLE;
        end else if (cnt == 4'd0) begin
          state_next = ST_DONE;
          do_done    = 1'b1;
        end else begin
          do_dec = 1'b1;
        end
      end
      ST_DONE: begin
        if (!psel) begin
          state_next = ST_IDLE;
          do_clear   = 1'b1;
        end else if (penable) begin
          state_next = ST_IDLE;
          do_clear   = 1'b1;
          do_commit  = lat_write && !lat_err;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
      prdata    <= '0;
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      lat_strb  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_next;
      if (do_setup) begin
        lat_write <= pwrite;
        lat_err   <= setup_err;
        lat_idx   <= setup_idx[MEM_AW-1:0];
        lat_wdata <= pwdata;
        lat_strb  <= pstrb;
        cnt       <= CNT_INIT;
      end else if (do_dec) begin
        cnt <= cnt - 4'd1;
      end
      if (do_done) begin
        pready  <= 1'b1;
        pslverr <= done_err;
        prdata  <= (!done_write && !done_err) ? mem[done_idx] : '0;
      end else if (do_clear) begin
        pready  <= 1'b0;
        pslverr <= 1'b0;
      end
      if (do_commit) begin
        for (int b = 0; b < BYTES; b++) begin
          if (lat_strb[b]) mem[lat_idx][b*8 +: 8] <= lat_wdata[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: a zero-wait and a three-wait instance share one bus,
// psel steers each transfer to one of them; a word-array model predicts results.
module tb_apb_mem_slave;

  logic        pclk;
  logic        presetn;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  int          sel;

  logic        psel0, psel3, penable0, penable3;
  logic        pready0, pready3, pslverr0, pslverr3;
  logic [31:0] prdata0, prdata3;
  logic        pready_m, pslverr_m;
  logic [31:0] prdata_m;

  int compared;
  int mismatched;
  logic [31:0] model [2][64];

  assign psel0    = psel && (sel == 0);
  assign psel3    = psel && (sel == 1);
  assign penable0 = penable && (sel == 0);
  assign penable3 = penable && (sel == 1);
  assign pready_m  = (sel == 1) ? pready3  : pready0;
  assign pslverr_m = (sel == 1) ? pslverr3 : pslverr0;
  assign prdata_m  = (sel == 1) ? prdata3  : prdata0;

  apb_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(64), .WAIT_STATES(0)) dut0 (
    .pclk(pclk), .presetn(presetn), .psel(psel0), .penable(penable0), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready0), .prdata(prdata0), .pslverr(pslverr0)
  );

  apb_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(64), .WAIT_STATES(3)) dut3 (
    .pclk(pclk), .presetn(presetn), .psel(psel3), .penable(penable3), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready3), .prdata(prdata3), .pslverr(pslverr3)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 64; i++) model[d][i] = 32'h0;
  endtask

  // One complete transfer; pready must stay low for the wait cycles of the
  // selected instance and rise on the following access cycle.
  task automatic xfer(input int which, input bit wr, input logic [11:0] addr,
                      input logic [31:0] data, input logic [3:0] strb);
    int ws;
    int idx;
    bit err;
    logic [31:0] exp_rd;
    ws     = (which == 1) ? 3 : 0;
    idx    = int'(addr >> 2);
    err    = (idx >= 64);
    exp_rd = (!wr && !err) ? model[which][idx] : 32'h0;
    sel = which; psel = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    tick();
    penable = 1'b1;
    for (int c = 0; c < ws; c++) begin
      chk("wait_pready_low", {31'b0, pready_m}, 32'h0);
      tick();
    end
    chk("pready_high", {31'b0, pready_m}, 32'h1);
    chk("pslverr", {31'b0, pslverr_m}, {31'b0, err});
    if (!wr) chk("prdata", prdata_m, exp_rd);
    tick();
    psel = 1'b0; penable = 1'b0;
    chk("pready_clear", {31'b0, pready_m}, 32'h0);
    chk("pslverr_clear", {31'b0, pslverr_m}, 32'h0);
    if (wr && !err) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[which][idx][b*8 +: 8] = data[b*8 +: 8];
    end
  endtask

  initial begin
    logic [11:0] ra;
    compared = 0; mismatched = 0;
    sel = 0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; pstrb = '0;
    clear_model();
    presetn = 1'b0;
    repeat (3) tick();
    chk("rst_pready0", {31'b0, pready0}, 32'h0);
    chk("rst_pslverr0", {31'b0, pslverr0}, 32'h0);
    chk("rst_prdata0", prdata0, 32'h0);
    chk("rst_pready3", {31'b0, pready3}, 32'h0);
    chk("rst_prdata3", prdata3, 32'h0);
    presetn = 1'b1;
    tick();

    // zero-wait write/read and byte strobes
    xfer(0, 1, 12'h010, 32'hDEADBEEF, 4'hF);
    xfer(0, 0, 12'h010, 32'h0, 4'h0);
    chk("deadbeef", model[0][4], 32'hDEADBEEF);
    xfer(0, 1, 12'h020, 32'h11223344, 4'hF);
    xfer(0, 1, 12'h020, 32'hAABBCCDD, 4'h5);
    xfer(0, 0, 12'h020, 32'h0, 4'h0);
    chk("strobe_merge", model[0][8], 32'h11BB33DD);

    // wait-state instance
    xfer(1, 0, 12'h010, 32'h0, 4'h0);
    xfer(1, 1, 12'h044, 32'hCAFEF00D, 4'hF);
    xfer(1, 0, 12'h046, 32'h0, 4'h0);

    // out of range and empty strobe
    xfer(0, 1, 12'h100, 32'h55555555, 4'hF);
    xfer(0, 0, 12'h100, 32'h0, 4'h0);
    xfer(1, 1, 12'hFFC, 32'h66666666, 4'hF);
    xfer(1, 0, 12'h100, 32'h0, 4'h0);
    xfer(0, 0, 12'h000, 32'h0, 4'h0);
    xfer(0, 1, 12'h010, 32'h12345678, 4'h0);
    xfer(0, 0, 12'h010, 32'h0, 4'h0);

    // back-to-back, no idle cycles
    for (int d = 0; d < 2; d++) begin
      xfer(d, 1, 12'h000, 32'h1, 4'hF);
      xfer(d, 1, 12'h004, 32'h2, 4'hF);
      xfer(d, 1, 12'h008, 32'h3, 4'hF);
      xfer(d, 0, 12'h000, 32'h0, 4'h0);
      xfer(d, 0, 12'h004, 32'h0, 4'h0);
      xfer(d, 0, 12'h008, 32'h0, 4'h0);
    end

    // penable without a setup phase is ignored
    sel = 0; psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 12'h00C;
    pwdata = 32'hBAD0BAD0; pstrb = 4'hF;
    tick();
    chk("idle_penable_1", {31'b0, pready0}, 32'h0);
    tick();
    chk("idle_penable_2", {31'b0, pready0}, 32'h0);
    psel = 1'b0; penable = 1'b0;
    tick();
    xfer(0, 0, 12'h00C, 32'h0, 4'h0);

    // psel dropped during wait states aborts the write
    sel = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h004;
    pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    tick();
    penable = 1'b1;
    tick();
    chk("abort_pready", {31'b0, pready3}, 32'h0);
    psel = 1'b0; penable = 1'b0;
    tick();
    tick();
    chk("abort_idle", {31'b0, pready3}, 32'h0);
    xfer(1, 0, 12'h004, 32'h0, 4'h0);

    // randomized traffic on both instances
    for (int n = 0; n < 80; n++) begin
      ra = 12'($urandom_range(0, 12'h13F));
      xfer(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, $urandom,
           4'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) == 0) tick();
    end
    for (int i = 0; i < 64; i += 7) begin
      xfer(0, 0, 12'(i * 4), 32'h0, 4'h0);
      xfer(1, 0, 12'(i * 4), 32'h0, 4'h0);
    end

    // reset during the wait phase of a write
    sel = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h080;
    pwdata = 32'hA5A5A5A5; pstrb = 4'hF;
    tick();
    penable = 1'b1;
    #2 presetn = 1'b0;
    clear_model();
    #2 psel = 1'b0; penable = 1'b0;
    tick();
    presetn = 1'b1;
    tick();
    xfer(1, 0, 12'h080, 32'h0, 4'h0);

    // asynchronous reset mid-cycle while a read response is presented
    xfer(0, 1, 12'h030, 32'h87654321, 4'hF);
    sel = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h030;
    tick();
    penable = 1'b1;
    chk("pre_rst_prdata", prdata0, 32'h87654321);
    #3 presetn = 1'b0;
    clear_model();
    #1;
    chk("async_rst_pready", {31'b0, pready0}, 32'h0);
    chk("async_rst_pslverr", {31'b0, pslverr0}, 32'h0);
    chk("async_rst_prdata", prdata0, 32'h0);
    psel = 1'b0; penable = 1'b0;
    #2 presetn = 1'b1;
    tick();
    xfer(0, 0, 12'h014, 32'h0, 4'h0);
    xfer(0, 0, 12'h030, 32'h0, 4'h0);
    xfer(1, 0, 12'h014, 32'h0, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
